// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage with operand forwarding muxes, ALU and EXE/MEM register.
// Define EXE_MUL_EN to build the iterative shift-add multiplier (opcode 10) and its stall FSM.
module exe_stage
`ifdef EXE_MUL_EN
#(
  parameter int MUL_CYCLES = 32
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [3:0]  exe_cmd,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [31:0] st_val,
  input  logic [1:0]  sel_alu_in1,
  input  logic [1:0]  sel_alu_in2,
  input  logic [1:0]  sel_st,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] wb_value,
  input  logic [4:0]  dest_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  output logic [31:0] alu_result,
  output logic [31:0] st_val_out,
  output logic [4:0]  dest_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        stall_out
);

  localparam int DATA_W = 32;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_AND = 4'd2;
  localparam logic [3:0] CMD_OR  = 4'd3;
  localparam logic [3:0] CMD_NOR = 4'd4;
  localparam logic [3:0] CMD_XOR = 4'd5;
  localparam logic [3:0] CMD_SLL = 4'd6;
  localparam logic [3:0] CMD_SRL = 4'd7;
  localparam logic [3:0] CMD_SRA = 4'd8;
  localparam logic [3:0] CMD_SLT = 4'd9;
  localparam logic [3:0] CMD_MUL = 4'd10;

  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Select 11 is unused by the forwarding unit and falls back to the ID/EXE value.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] id_v,
    input logic [DATA_W-1:0] wb_v,
    input logic [DATA_W-1:0] mem_v
  );
    case (sel)
      FWD_WB:  return wb_v;
      FWD_MEM: return mem_v;
      default: return id_v;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu_f(
    input logic [3:0]        cmd,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [4:0]               sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    case (cmd)
      CMD_ADD: return a + b;
      CMD_SUB: return a - b;
      CMD_AND: return a & b;
      CMD_OR:  return a | b;
      CMD_NOR: return ~(a | b);
      CMD_XOR: return a ^ b;
      CMD_SLL: return a << sh;
      CMD_SRL: return a >> sh;
      CMD_SRA: return $unsigned(sa >>> sh);
      CMD_SLT: return (sa < sb) ? 32'd1 : 32'd0;
      CMD_MUL: return '0;
      default: return '0;
    endcase
  endfunction

  logic [DATA_W-1:0] op1, op2, st_fwd, exe_res;

  assign op1    = fwd_sel(sel_alu_in1, val1, wb_value, alu_result_mem);
  assign op2    = fwd_sel(sel_alu_in2, val2, wb_value, alu_result_mem);
  assign st_fwd = fwd_sel(sel_st, st_val, wb_value, alu_result_mem);

`ifdef EXE_MUL_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int         CNT_W   = $clog2(MUL_CYCLES + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic              mul_stall;

  // Operands are captured on entry because the forwarding sources move on during the stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    mul_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exe_cmd == CMD_MUL) begin
          mul_stall = 1'b1;
          mcand_d   = op1;
          mplier_d  = op2;
          prod_d    = '0;
          cnt_d     = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mul_stall = 1'b1;
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!freeze) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
  end

  assign stall_out = mul_stall;
  assign exe_res   = (state_q == ST_DONE) ? prod_q : alu_f(exe_cmd, op1, op2);
`else
  assign stall_out = 1'b0;
  assign exe_res   = alu_f(exe_cmd, op1, op2);
`endif

  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic [4:0]        dest_q, dest_d;
  logic              wb_en_q, wb_en_d;
  logic              mem_r_q, mem_r_d;
  logic              mem_w_q, mem_w_d;

  // EXE/MEM register: freeze holds, a stall inserts a bubble, otherwise load.
  always_comb begin
    alu_d   = alu_q;
    st_d    = st_q;
    dest_d  = dest_q;
    wb_en_d = wb_en_q;
    mem_r_d = mem_r_q;
    mem_w_d = mem_w_q;
    if (!freeze) begin
      if (stall_out) begin
        alu_d   = '0;
        st_d    = '0;
        dest_d  = '0;
        wb_en_d = 1'b0;
        mem_r_d = 1'b0;
        mem_w_d = 1'b0;
      end else begin
        alu_d   = exe_res;
        st_d    = st_fwd;
        dest_d  = dest_in;
        wb_en_d = wb_en_in;
        mem_r_d = mem_r_en_in;
        mem_w_d = mem_w_en_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= '0;
      st_q    <= '0;
      dest_q  <= '0;
      wb_en_q <= 1'b0;
      mem_r_q <= 1'b0;
      mem_w_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      st_q    <= st_d;
      dest_q  <= dest_d;
      wb_en_q <= wb_en_d;
      mem_r_q <= mem_r_d;
      mem_w_q <= mem_w_d;
    end
  end

  assign alu_result   = alu_q;
  assign st_val_out   = st_q;
  assign dest_out     = dest_q;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_q;
  assign mem_w_en_out = mem_w_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage; multiply scenarios are compiled only with EXE_MUL_EN.
module tb_exe_stage;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, NOR_ = 4'd4,
                         XOR_ = 4'd5, SLL = 4'd6, SRL = 4'd7, SRA = 4'd8, SLT = 4'd9,
                         MUL = 4'd10;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [3:0]  exe_cmd;
  logic [31:0] val1, val2, st_val, alu_result_mem, wb_value;
  logic [1:0]  sel_alu_in1, sel_alu_in2, sel_st;
  logic [4:0]  dest_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_result, st_val_out;
  logic [4:0]  dest_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, stall_out;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .exe_cmd(exe_cmd),
    .val1(val1), .val2(val2), .st_val(st_val),
    .sel_alu_in1(sel_alu_in1), .sel_alu_in2(sel_alu_in2), .sel_st(sel_st),
    .alu_result_mem(alu_result_mem), .wb_value(wb_value),
    .dest_in(dest_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_result(alu_result), .st_val_out(st_val_out), .dest_out(dest_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  dest;
    logic [2:0]  ctl;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  logic [4:0] next_dest = 5'd1;
  logic [4:0] last_dest = 5'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new instruction leaving EXE/MEM (enables set, new dest) is matched in order.
  always @(negedge clk) begin
    if (!rst && (wb_en_out || mem_r_en_out || mem_w_en_out) && dest_out != last_dest) begin
      last_dest = dest_out;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got dest %0d expected no output", dest_out);
      end else begin
        mon_e = sb_q.pop_front();
        check32("sb_res", alu_result, mon_e.res);
        check32("sb_st", st_val_out, mon_e.st);
        check32("sb_dest", {27'd0, dest_out}, {27'd0, mon_e.dest});
        check32("sb_ctl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, {29'd0, mon_e.ctl});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] st, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] ss, input logic [2:0] ctl);
    exe_cmd = cmd; val1 = v1; val2 = v2; st_val = st;
    sel_alu_in1 = s1; sel_alu_in2 = s2; sel_st = ss;
    {wb_en_in, mem_r_en_in, mem_w_en_in} = ctl;
    dest_in = next_dest;
    next_dest = (next_dest == 5'd31) ? 5'd1 : next_dest + 5'd1;
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] st);
    exp_t e;
    e.res = res; e.st = st; e.dest = dest_in;
    e.ctl = {wb_en_in, mem_r_en_in, mem_w_en_in};
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] st, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] ss, input logic [2:0] ctl,
                       input logic [31:0] res, input logic [31:0] exp_st);
    drive(cmd, v1, v2, st, s1, s2, ss, ctl);
    push(res, exp_st);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    rst = 1'b1; freeze = 1'b0; exe_cmd = ADD;
    val1 = '0; val2 = '0; st_val = '0; alu_result_mem = '0; wb_value = '0;
    sel_alu_in1 = '0; sel_alu_in2 = '0; sel_st = '0;
    dest_in = '0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_alu", alu_result, 32'h0);
    check32("rst_st", st_val_out, 32'h0);
    check32("rst_dest", {27'd0, dest_out}, 32'h0);
    check32("rst_ctl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'h0);
    check32("rst_stall", {31'd0, stall_out}, 32'h0);
    rst = 1'b0;

    alu_result_mem = 32'h10;
    wb_value       = 32'h1;
    // cmd, val1, val2, st_val, sel1, sel2, sel_st, {wb,mr,mw}, expected result, expected store
    issue(ADD,  32'h0000DEAD, 32'h5,        32'h0,    2'b10, 2'b00, 2'b00, 3'b100, 32'h15,       32'h0);
    issue(SUB,  32'h0,        32'hAA,       32'h0,    2'b00, 2'b01, 2'b00, 3'b100, 32'hFFFFFFFF, 32'h0);
    issue(SLT,  32'hFFFFFFFF, 32'h1,        32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'h1,        32'h0);
    issue(SLT,  32'h1,        32'hFFFFFFFF, 32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'h0,        32'h0);
    issue(SRA,  32'h80000000, 32'hFFFFFFE4, 32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'hF8000000, 32'h0);
    issue(SRL,  32'h80000000, 32'h4,        32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'h08000000, 32'h0);
    issue(SLL,  32'h1,        32'h1F,       32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'h80000000, 32'h0);
    issue(AND_, 32'hF0F01234, 32'h0FF0FF00, 32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'h00F01200, 32'h0);
    issue(OR_,  32'hF0000000, 32'h0000000F, 32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'hF000000F, 32'h0);
    issue(NOR_, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'h0000000F, 32'h0);
    issue(XOR_, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'hF0F00F0F, 32'h0);
    issue(ADD,  32'hFFFFFFFF, 32'h2,        32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'h1,        32'h0);
    issue(ADD,  32'h3,        32'h4,        32'h0,    2'b11, 2'b11, 2'b00, 3'b100, 32'h7,        32'h0);
    issue(ADD,  32'h1,        32'h2,        32'h5555, 2'b00, 2'b00, 2'b10, 3'b001, 32'h3,        32'h10);
    issue(ADD,  32'h1,        32'h2,        32'h5555, 2'b00, 2'b00, 2'b01, 3'b001, 32'h3,        32'h1);
    issue(ADD,  32'h100,      32'h4,        32'h6666, 2'b00, 2'b00, 2'b11, 3'b110, 32'h104,      32'h6666);
    issue(4'd12, 32'h7,       32'h9,        32'h0,    2'b00, 2'b00, 2'b00, 3'b100, 32'h0,        32'h0);

    // Freeze holds the previous result; the waiting instruction lands once freeze drops.
    issue(ADD, 32'd100, 32'd23, 32'h0, 2'b00, 2'b00, 2'b00, 3'b100, 32'd123, 32'h0);
    drive(XOR_, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 2'b00, 2'b00, 2'b00, 3'b100);
    push(32'hF0F00F0F, 32'h0);
    freeze = 1'b1;
    repeat (3) begin
      step();
      check32("freeze_hold", alu_result, 32'd123);
    end
    freeze = 1'b0;
    step();
    check32("freeze_release", alu_result, 32'hF0F00F0F);

    // Asynchronous reset between clock edges clears the register at once.
    issue(OR_, 32'h12340000, 32'h00005678, 32'h0, 2'b00, 2'b00, 2'b00, 3'b100, 32'h12345678, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    #1;
    check32("async_rst_alu", alu_result, 32'h0);
    check32("async_rst_wb", {31'd0, wb_en_out}, 32'h0);
    check32("async_rst_dest", {27'd0, dest_out}, 32'h0);
    step();
    rst = 1'b0;

`ifdef EXE_MUL_EN
    // Multiply with op1 forwarded from MEM; the source changes mid-stall.
    alu_result_mem = 32'h00010003;
    drive(MUL, 32'hBAD0BAD0, 32'h5, 32'h0, 2'b10, 2'b00, 2'b00, 3'b100);
    push(32'h0005000F, 32'h0);
    #1;
    check32("mul_stall_entry", {31'd0, stall_out}, 32'h1);
    n = 0;
    guard = 0;
    while (stall_out && guard < 100) begin
      n++;
      guard++;
      step();
      if (guard == 1) begin
        alu_result_mem = 32'hFFFFFFFF;
        wb_value       = 32'h12345678;
        check32("mul_bubble_wb", {31'd0, wb_en_out}, 32'h0);
        check32("mul_bubble_alu", alu_result, 32'h0);
      end
    end
    check32("mul_stall_cycles", n, 33);
    step();
    check32("mul_result", alu_result, 32'h0005000F);

    // Freeze across the whole multiply, including three cycles in DONE.
    drive(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2'b00, 2'b00, 2'b00, 3'b100);
    push(32'h1, 32'h0);
    freeze = 1'b1;
    #1;
    n = 0;
    guard = 0;
    while (stall_out && guard < 100) begin
      n++;
      guard++;
      step();
      if (guard == 5) check32("mulfrz_hold_busy", alu_result, 32'h0005000F);
    end
    check32("mulfrz_stall_cycles", n, 33);
    repeat (3) begin
      step();
      check32("mulfrz_hold_done", alu_result, 32'h0005000F);
      check32("mulfrz_stall_done", {31'd0, stall_out}, 32'h0);
    end
    freeze = 1'b0;
    step();
    check32("mulfrz_result", alu_result, 32'h1);

    // Reset during BUSY: frozen register holds a known value until rst clears it.
    issue(ADD, 32'h40, 32'h2, 32'h0, 2'b00, 2'b00, 2'b00, 3'b100, 32'h42, 32'h0);
    drive(MUL, 32'h7, 32'h9, 32'h0, 2'b00, 2'b00, 2'b00, 3'b100);
    freeze = 1'b1;
    repeat (10) step();
    check32("busy_hold", alu_result, 32'h42);
    #2;
    rst = 1'b1;
    exe_cmd = ADD;
    wb_en_in = 1'b0;
    freeze = 1'b0;
    #1;
    check32("busy_rst_alu", alu_result, 32'h0);
    check32("busy_rst_wb", {31'd0, wb_en_out}, 32'h0);
    check32("busy_rst_stall", {31'd0, stall_out}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check32("post_rst_stall", {31'd0, stall_out}, 32'h0);
    issue(ADD, 32'h6, 32'h7, 32'h0, 2'b00, 2'b00, 2'b00, 3'b100, 32'hD, 32'h0);
    check32("post_rst_add", alu_result, 32'hD);
`else
    // Without the multiplier opcode 10 is an ordinary single-cycle zero result.
    drive(MUL, 32'h3, 32'h4, 32'h0, 2'b00, 2'b00, 2'b00, 3'b100);
    push(32'h0, 32'h0);
    #1;
    check32("nomul_stall", {31'd0, stall_out}, 32'h0);
    step();
    check32("nomul_stall_after", {31'd0, stall_out}, 32'h0);
    check32("nomul_result", alu_result, 32'h0);
`endif

    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    repeat (3) step();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
